maxpool2x2_stream: RTL and testbench

- Streaming 2x2, stride-2 max-pool engine for the maxpool path.
- Consumes a row-major feature-map stream where each beat carries CH_NUM channel lanes of DATA_W bits.
- Keeps the horizontal pair maxima of each even row in an internal line buffer, then emits one pooled beat per 2x2 window on the odd row.
- Adds over the per-lane comparator: run-time signed/unsigned mode, configurable map size, valid/ready backpressure, and a frame-done pulse.

---
 rtl/maxpool2x2_stream.sv | 179 +++++++++++++++++
 tb/tb_maxpool2x2_stream.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over a row-major multi-lane pixel stream.
// Even-row pair maxima are parked in a line buffer and merged on the odd row.
module maxpool2x2_stream #(
   parameter int DATA_W   = 8,
   parameter int CH_NUM   = 16,
   parameter int MAX_COLS = 416,
   parameter int DIM_W    = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [DIM_W-1:0]         col_num,
   input  logic [DIM_W-1:0]         row_num,
   input  logic                     sign_mode,
   input  logic [DATA_W*CH_NUM-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [DATA_W*CH_NUM-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy,
   output logic                     done
);

   localparam int BUS_W    = DATA_W * CH_NUM;
   localparam int LB_DEPTH = MAX_COLS / 2;
   localparam int LB_AW    = $clog2(LB_DEPTH);
   localparam logic [DIM_W-1:0] DIM_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};
   localparam logic [DIM_W-1:0] DIM_ZERO = {DIM_W{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic logic [BUS_W-1:0] lane_max(
      input logic [BUS_W-1:0] a,
      input logic [BUS_W-1:0] b,
      input logic             sgn
   );
      logic [BUS_W-1:0]  res;
      logic [DATA_W-1:0] la;
      logic [DATA_W-1:0] lb;
      logic              a_gt;
      res = {BUS_W{1'b0}};
      for (int i = 0; i < CH_NUM; i++) begin
         la = a[i*DATA_W +: DATA_W];
         lb = b[i*DATA_W +: DATA_W];
         if (sgn) begin
            a_gt = ($signed(la) > $signed(lb));
         end else begin
            a_gt = (la > lb);
         end
         res[i*DATA_W +: DATA_W] = a_gt ? la : lb;
      end
      return res;
   endfunction

   state_t             state_r;
   logic [DIM_W-1:0]   col_r;
   logic [DIM_W-1:0]   row_r;
   logic [DIM_W-1:0]   col_num_r;
   logic [DIM_W-1:0]   row_num_r;
   logic               sign_mode_r;
   logic [BUS_W-1:0]   hold_r;
   logic [BUS_W-1:0]   out_data_r;
   logic               out_valid_r;
   logic               busy_r;
   logic               done_r;
   logic [BUS_W-1:0]   linebuf_r [0:LB_DEPTH-1];

   logic               in_ready_s;
   logic               accept_s;
   logic               last_col_s;
   logic               last_row_s;
   logic               hold_we_s;
   logic               lb_we_s;
   logic               emit_s;
   logic [LB_AW-1:0]   lb_addr_s;
   logic [BUS_W-1:0]   lb_rd_s;
   logic [BUS_W-1:0]   pair_max_s;
   logic [BUS_W-1:0]   pool_s;

   // Beat qualification and per-lane datapath for the current input beat.
   always_comb begin
      in_ready_s = (state_r == ST_RUN) && (!out_valid_r || out_ready);
      accept_s   = in_valid && in_ready_s;
      last_col_s = (col_r == (col_num_r - DIM_ONE));
      last_row_s = (row_r == (row_num_r - DIM_ONE));
      // A trailing even column or even row has no partner and is dropped.
      hold_we_s  = accept_s && !col_r[0] && !last_col_s;
      lb_we_s    = accept_s && col_r[0] && !row_r[0] && !last_row_s;
      emit_s     = accept_s && col_r[0] && row_r[0];
      lb_addr_s  = col_r[LB_AW:1];
      lb_rd_s    = linebuf_r[lb_addr_s];
      pair_max_s = lane_max(hold_r, in_data, sign_mode_r);
      pool_s     = lane_max(lb_rd_s, pair_max_s, sign_mode_r);
   end

   // Line buffer of even-row horizontal pair maxima; contents need no reset.
   always_ff @(posedge clk) begin
      if (lb_we_s) begin
         linebuf_r[lb_addr_s] <= pair_max_s;
      end
   end

   // Control FSM, counters, hold register and the single output slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         col_r       <= DIM_ZERO;
         row_r       <= DIM_ZERO;
         col_num_r   <= DIM_ZERO;
         row_num_r   <= DIM_ZERO;
         sign_mode_r <= 1'b0;
         hold_r      <= {BUS_W{1'b0}};
         out_data_r  <= {BUS_W{1'b0}};
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (hold_we_s) begin
            hold_r <= in_data;
         end
         if (emit_s) begin
            out_data_r  <= pool_s;
            out_valid_r <= 1'b1;
         end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
         end
         if (accept_s) begin
            if (last_col_s) begin
               col_r <= DIM_ZERO;
               row_r <= row_r + DIM_ONE;
            end else begin
               col_r <= col_r + DIM_ONE;
            end
         end
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  col_num_r   <= col_num;
                  row_num_r   <= row_num;
                  sign_mode_r <= sign_mode;
                  col_r       <= DIM_ZERO;
                  row_r       <= DIM_ZERO;
                  busy_r      <= 1'b1;
                  state_r     <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (accept_s && last_col_s && last_row_s) begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!out_valid_r || out_ready) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_s;
   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard bench for maxpool2x2_stream: stimulus pushes expected pooled beats,
// an independent monitor pops and compares each beat the DUT hands downstream.
module tb_maxpool2x2_stream;

   localparam int DATA_W = 8;
   localparam int CH_NUM = 16;
   localparam int BUS_W  = DATA_W * CH_NUM;
   localparam int DIM_W  = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [DIM_W-1:0]  col_num = '0;
   logic [DIM_W-1:0]  row_num = '0;
   logic              sign_mode = 1'b0;
   logic [BUS_W-1:0]  in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [BUS_W-1:0]  out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              busy;
   logic              done;

   int                checks = 0;
   int                errors = 0;
   int                ready_mode = 0;
   logic              toggle = 1'b0;
   time               last_pop_t = 0;
   logic [BUS_W-1:0]  exp_q [$];
   logic [BUS_W-1:0]  pix [0:63];

   always #5 clk = ~clk;

   maxpool2x2_stream #(.DATA_W(DATA_W), .CH_NUM(CH_NUM), .MAX_COLS(416), .DIM_W(DIM_W)) dut (
      .clk(clk), .rst(rst), .start(start), .col_num(col_num), .row_num(row_num),
      .sign_mode(sign_mode), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   task automatic check(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] pick(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input bit sgn);
      if (sgn) return ($signed(a) >= $signed(b)) ? a : b;
      else     return (a >= b) ? a : b;
   endfunction

   // Reference: window maximum taken directly from the stored frame.
   function automatic logic [BUS_W-1:0] win_max(input int cols, input int wr, input int wc, input bit sgn);
      logic [BUS_W-1:0]  r;
      logic [DATA_W-1:0] m;
      r = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         m = pix[(2*wr)*cols + 2*wc][i*DATA_W +: DATA_W];
         m = pick(m, pix[(2*wr)*cols + 2*wc + 1][i*DATA_W +: DATA_W], sgn);
         m = pick(m, pix[(2*wr+1)*cols + 2*wc][i*DATA_W +: DATA_W], sgn);
         m = pick(m, pix[(2*wr+1)*cols + 2*wc + 1][i*DATA_W +: DATA_W], sgn);
         r[i*DATA_W +: DATA_W] = m;
      end
      return r;
   endfunction

   function automatic logic [BUS_W-1:0] lane0(input int v);
      logic [BUS_W-1:0] r;
      r = '0;
      r[DATA_W-1:0] = v[DATA_W-1:0];
      return r;
   endfunction

   // Downstream ready pattern: 0 = always, 1 = alternating, 2 = stalled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         toggle = ~toggle;
         if (ready_mode == 0)      out_ready = 1'b1;
         else if (ready_mode == 1) out_ready = toggle;
         else                      out_ready = 1'b0;
      end
   end

   // Monitor: pop/compare on every handshake, and watch backpressure.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         last_pop_t = $time;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h expected none", out_data);
         end else begin
            check("out_data", out_data, exp_q.pop_front());
         end
      end
      if (rst && out_valid && !out_ready) begin
         check("in_ready_stall", lane0(int'(in_ready)), lane0(0));
      end
   end

   task automatic start_frame(input int cols, input int rows, input bit sgn);
      col_num   = cols[DIM_W-1:0];
      row_num   = rows[DIM_W-1:0];
      sign_mode = sgn;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic feed(input int n);
      int t;
      for (int p = 0; p < n; p++) begin
         in_data  = pix[p];
         in_valid = 1'b1;
         t = 0;
         @(negedge clk);
         while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
         end
         if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got in_ready=0 expected 1 at beat %0d", p);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input bit check_latency);
      int t;
      t = 0;
      @(negedge clk);
      while (!done && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got done=0 expected 1");
         return;
      end
      check("queue_empty_at_done", lane0(exp_q.size()), lane0(0));
      check("busy_at_done", lane0(int'(busy)), lane0(0));
      if (check_latency) check("done_latency", lane0(int'($time - last_pop_t)), lane0(10));
      @(negedge clk);
      check("done_pulse_width", lane0(int'(done)), lane0(0));
      @(posedge clk);
      #1;
   endtask

   task automatic load_ramp4x4(input bit down);
      for (int p = 0; p < 16; p++) pix[p] = lane0(down ? 15 - p : p);
   endtask

   initial begin
      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", lane0(int'(out_valid)), lane0(0));
      check("rst_busy", lane0(int'(busy)), lane0(0));
      check("rst_done", lane0(int'(done)), lane0(0));
      check("rst_in_ready", lane0(int'(in_ready)), lane0(0));
      check("rst_out_data", out_data, '0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Unsigned 4x4 ramp.
      ready_mode = 0;
      load_ramp4x4(1'b0);
      exp_q.push_back(lane0(5));
      exp_q.push_back(lane0(7));
      exp_q.push_back(lane0(13));
      exp_q.push_back(lane0(15));
      start_frame(4, 4, 1'b0);
      check("busy_in_run", lane0(int'(busy)), lane0(1));
      feed(16);
      wait_done(1'b1);

      // 2x2 signed then unsigned interpretation of the same pixels.
      pix[0] = lane0(8'h80); pix[1] = lane0(8'h7F); pix[2] = lane0(8'hFF); pix[3] = lane0(8'h01);
      exp_q.push_back(lane0(8'h7F));
      start_frame(2, 2, 1'b1);
      feed(4);
      wait_done(1'b1);
      exp_q.push_back(lane0(8'hFF));
      start_frame(2, 2, 1'b0);
      feed(4);
      wait_done(1'b1);

      // Backpressure: alternating out_ready, same 4x4 results.
      ready_mode = 1;
      load_ramp4x4(1'b0);
      exp_q.push_back(lane0(5));
      exp_q.push_back(lane0(7));
      exp_q.push_back(lane0(13));
      exp_q.push_back(lane0(15));
      start_frame(4, 4, 1'b0);
      feed(16);
      wait_done(1'b1);
      ready_mode = 0;

      // Odd 5x3 frame, random signed data: column 4 and row 2 ignored.
      for (int p = 0; p < 15; p++) pix[p] = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(win_max(5, 0, 0, 1'b1));
      exp_q.push_back(win_max(5, 0, 1, 1'b1));
      start_frame(5, 3, 1'b1);
      feed(15);
      wait_done(1'b0);

      // All 16 lanes, 8x2: lane i holds i*3+{0..3} rotated, max is always i*3+3.
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < CH_NUM; i++) begin
               pix[r*8+c][i*DATA_W +: DATA_W] = 8'(i*3 + ((r*2 + c%2 + c/2 + i) % 4));
            end
         end
      end
      for (int w = 0; w < 4; w++) begin
         logic [BUS_W-1:0] e;
         for (int i = 0; i < CH_NUM; i++) e[i*DATA_W +: DATA_W] = 8'(i*3 + 3);
         exp_q.push_back(e);
      end
      start_frame(8, 2, 1'b0);
      feed(16);
      wait_done(1'b1);

      // Abort a frame with an output pending, then run a fresh frame.
      ready_mode = 2;
      load_ramp4x4(1'b0);
      start_frame(4, 4, 1'b0);
      feed(6);
      @(negedge clk);
      check("abort_pending_valid", lane0(int'(out_valid)), lane0(1));
      rst = 1'b0;
      #1;
      check("abort_out_valid", lane0(int'(out_valid)), lane0(0));
      check("abort_busy", lane0(int'(busy)), lane0(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      ready_mode = 0;
      @(posedge clk);
      #1;
      load_ramp4x4(1'b1);
      exp_q.push_back(lane0(15));
      exp_q.push_back(lane0(13));
      exp_q.push_back(lane0(7));
      exp_q.push_back(lane0(5));
      start_frame(4, 4, 1'b0);
      feed(16);
      wait_done(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
